// File: rtl/mips_tb_pkg.sv
// Shared types and constants for the MIPS program checker.
// The state enum is used by the checker FSM; word constants by the store.
package mips_tb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_CHECK,
    S_DONE
  } chk_state_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/prog_rom.sv
// Program store: synchronous write, asynchronous read, fetch decode.
// Out-of-range or misaligned fetches return a NOP and flag a fault.
module prog_rom
  import mips_tb_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter logic [31:0] BASE  = DEF_RESET_VECTOR,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [31:0]   wr_data,
  input  logic [31:0]   rd_addr,
  input  logic          run,
  output logic [31:0]   rd_data,
  output logic          fetch_fault
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] off;
  logic        in_range;
  logic        aligned;
  logic        hit;

  // Contents survive reset so a loaded program can be rerun.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign off      = rd_addr - BASE;
  assign in_range = (off >> (AW + 2)) == 32'd0;
  assign aligned  = off[1:0] == 2'b00;
  assign hit      = in_range & aligned;

  assign rd_data     = hit ? mem_q[off[AW+1:2]] : NOP_WORD;
  assign fetch_fault = run & ~hit;

endmodule

// File: rtl/mips_prog_checker.sv
// Run/check harness for the Harvard MIPS core: serves a loaded program,
// sequences CPU reset and run, then grades register_v0 on halt or timeout.
module mips_prog_checker
  import mips_tb_pkg::*;
#(
  parameter int unsigned PROG_DEPTH     = 64,
  parameter logic [31:0] RESET_VECTOR   = DEF_RESET_VECTOR,
  parameter int unsigned TIMEOUT_CYCLES = 10000,
  parameter int unsigned RST_CYCLES     = 2,
  localparam int unsigned AW            = $clog2(PROG_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [31:0]   expected_v0,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          cpu_reset,
  output logic          cpu_clk_enable,
  input  logic          active,
  input  logic [31:0]   register_v0,
  input  logic [31:0]   instr_address,
  output logic [31:0]   instr_readdata,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          fault,
  output logic          timeout,
  output logic [31:0]   cycle_count
);

  localparam int unsigned RCW =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYCLES - 1);
  localparam logic [31:0]    TO_LAST  = 32'(TIMEOUT_CYCLES - 1);

  chk_state_t     state_q, state_d;
  logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
  logic [31:0]    cnt_q, cnt_d;
  logic [31:0]    exp_q, exp_d;
  logic           seen_q, seen_d;
  logic           fault_q, fault_d;
  logic           timeout_q, timeout_d;
  logic           pass_q, pass_d;

  logic           idle_or_done;
  logic           in_run;
  logic           fetch_fault;

  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign in_run       = state_q == S_RUN;

  prog_rom #(
    .DEPTH (PROG_DEPTH),
    .BASE  (RESET_VECTOR)
  ) u_rom (
    .clk         (clk),
    .wr_en       (load_en & idle_or_done),
    .wr_addr     (load_addr),
    .wr_data     (load_data),
    .rd_addr     (instr_address),
    .run         (in_run),
    .rd_data     (instr_readdata),
    .fetch_fault (fetch_fault)
  );

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_d     = cnt_q;
    exp_d     = exp_q;
    seen_d    = seen_q;
    fault_d   = fault_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d   = S_RST;
          rst_cnt_d = '0;
          cnt_d     = '0;
          exp_d     = expected_v0;
          seen_d    = 1'b0;
          fault_d   = 1'b0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      S_RST: begin
        if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 32'd1;
        if (active) seen_d = 1'b1;
        if (fetch_fault) fault_d = 1'b1;
        // A halt only counts once the core has been seen running.
        if (seen_q && !active) begin
          state_d = S_CHECK;
        end else if (cnt_q == TO_LAST) begin
          state_d   = S_CHECK;
          timeout_d = 1'b1;
        end
      end
      S_CHECK: begin
        pass_d  = (register_v0 == exp_q) & ~fault_q & ~timeout_q;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      rst_cnt_q <= '0;
      cnt_q     <= '0;
      exp_q     <= '0;
      seen_q    <= 1'b0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      cnt_q     <= cnt_d;
      exp_q     <= exp_d;
      seen_q    <= seen_d;
      fault_q   <= fault_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
    end
  end

  // CPU stays in reset while idle; frozen but readable after the run.
  assign cpu_reset      = (state_q == S_IDLE) || (state_q == S_RST);
  assign cpu_clk_enable = (state_q == S_RST) || (state_q == S_RUN);
  assign busy           = (state_q == S_RST) || (state_q == S_RUN) ||
                          (state_q == S_CHECK);
  assign done           = state_q == S_DONE;
  assign pass           = pass_q;
  assign fault          = fault_q;
  assign timeout        = timeout_q;
  assign cycle_count    = cnt_q;

endmodule

// File: tb/tb_mips_prog_checker.sv
// Bench for mips_prog_checker with a small instruction-level CPU stand-in.
module tb_mips_prog_checker;

  localparam logic [31:0] RV   = 32'hBFC0_0000;
  localparam int          RSTC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] expected_v0;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        cpu_reset;
  logic        cpu_clk_enable;
  logic        active;
  logic [31:0] register_v0;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        busy;
  logic        done;
  logic        pass;
  logic        fault;
  logic        timeout;
  logic [31:0] cycle_count;

  mips_prog_checker #(
    .PROG_DEPTH     (64),
    .RESET_VECTOR   (RV),
    .TIMEOUT_CYCLES (50),
    .RST_CYCLES     (RSTC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .expected_v0    (expected_v0),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .cpu_reset      (cpu_reset),
    .cpu_clk_enable (cpu_clk_enable),
    .active         (active),
    .register_v0    (register_v0),
    .instr_address  (instr_address),
    .instr_readdata (instr_readdata),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .fault          (fault),
    .timeout        (timeout),
    .cycle_count    (cycle_count)
  );

  always #5 clk = ~clk;

  int          checks;
  int          errors;
  logic [31:0] model_mem [64];
  logic [31:0] regs [32];
  logic [31:0] pc;
  logic        act_s;
  bit          manual;

  typedef struct {
    logic [31:0] addr;
    logic        hit;
  } fv_t;
  fv_t tbl [12];

  logic [31:0] prog_a [5];

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic wr_reg(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) regs[r] = v;
  endtask

  // Executes one instruction of the subset used by the programs here.
  task automatic iss_step(input logic [31:0] ir);
    logic [31:0] a, b, imm, npc;
    a   = regs[ir[25:21]];
    b   = regs[ir[20:16]];
    imm = {{16{ir[15]}}, ir[15:0]};
    npc = pc + 32'd4;
    case (ir[31:26])
      6'h09: wr_reg(ir[20:16], a + imm);
      6'h04: if (a == b) npc = pc + 32'd4 + (imm << 2);
      6'h00: begin
        case (ir[5:0])
          6'h21: wr_reg(ir[15:11], a + b);
          6'h24: wr_reg(ir[15:11], a & b);
          6'h25: wr_reg(ir[15:11], a | b);
          6'h08: begin
            if (a == 32'd0) begin
              act_s = 1'b0;
              npc   = pc;
            end else begin
              npc = a;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    pc = npc;
  endtask

  task automatic tick();
    logic        rs, en;
    logic [31:0] ir;
    @(negedge clk);
    rs = cpu_reset;
    en = cpu_clk_enable;
    ir = instr_readdata;
    @(posedge clk);
    #1;
    if (!manual && en) begin
      if (rs) begin
        pc    = RV;
        regs  = '{default: 32'h0};
        act_s = 1'b1;
      end else if (act_s) begin
        iss_step(ir);
      end
      instr_address = pc;
      active        = act_s;
      register_v0   = regs[2];
    end
    start   = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic load(input logic [5:0] a, input logic [31:0] d);
    load_en        = 1'b1;
    load_addr      = a;
    load_data      = d;
    model_mem[a]   = d;
    tick();
  endtask

  task automatic run_prog(input logic [31:0] ev, input bit ld,
                          input logic [5:0] la, input logic [31:0] lw,
                          input int dis, output int lat);
    expected_v0 = ev;
    start       = 1'b1;
    if (ld) begin
      load_en       = 1'b1;
      load_addr     = la;
      load_data     = lw;
      model_mem[la] = lw;
    end
    tick();
    chk1("start_busy", busy, 1'b1);
    chk1("start_cpu_reset", cpu_reset, 1'b1);
    lat = 0;
    while (!done && lat < 200) begin
      if (lat == dis) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 6'd0;
        load_data = 32'hDEAD_BEEF;
      end
      tick();
      lat++;
    end
    chk1("done_within_bound", done, 1'b1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] off, want;
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    start         = 1'b0;
    expected_v0   = 32'h0;
    load_en       = 1'b0;
    load_addr     = 6'd0;
    load_data     = 32'h0;
    active        = 1'b0;
    register_v0   = 32'h0;
    instr_address = RV;
    manual        = 1'b1;
    pc            = RV;
    act_s         = 1'b0;
    regs          = '{default: 32'h0};
    prog_a = '{32'h2403_0F0F, 32'h2401_00FF, 32'h0061_1025,
               32'h0040_1021, 32'h0000_0008};

    repeat (2) @(posedge clk);
    #1;
    chk1("rst_cpu_reset", cpu_reset, 1'b1);
    chk1("rst_clk_en", cpu_clk_enable, 1'b0);
    chk("rst_flags", {26'b0, busy, done, pass, fault, timeout, 1'b0},
        32'h0);
    chk("rst_cycles", cycle_count, 32'h0);
    reset = 1'b0;

    // Fetch decode against a randomly filled store.
    for (int i = 0; i < 64; i++) load(6'(i), $urandom);
    tbl = '{
      '{RV,              1'b1}, '{RV + 32'd4,   1'b1},
      '{RV + 32'd128,    1'b1}, '{RV + 32'd252, 1'b1},
      '{RV + 32'd256,    1'b0}, '{RV - 32'd4,   1'b0},
      '{RV + 32'd1,      1'b0}, '{RV + 32'd2,   1'b0},
      '{RV + 32'd3,      1'b0}, '{32'h0,        1'b0},
      '{32'hFFFF_FFFC,   1'b0}, '{RV + 32'd253, 1'b0}
    };
    for (int i = 0; i < 12; i++) begin
      instr_address = tbl[i].addr;
      #1;
      off  = tbl[i].addr - RV;
      want = tbl[i].hit ? model_mem[off[7:2]] : 32'h0;
      chk("fetch_tbl", instr_readdata, want);
    end
    for (int i = 0; i < 24; i++) begin
      off = 32'($urandom_range(0, 300));
      if ($urandom_range(0, 3) == 0) off = -32'($urandom_range(1, 64));
      instr_address = RV + off;
      #1;
      want = (off < 32'd256 && off[1:0] == 2'b00) ?
             model_mem[off[7:2]] : 32'h0;
      chk("fetch_rnd", instr_readdata, want);
    end
    chk1("idle_no_fault", fault, 1'b0);
    load(6'd9, 32'hA5A5_0009);
    instr_address = RV + 32'd36;
    #1;
    chk("load_next_cycle", instr_readdata, 32'hA5A5_0009);

    // Program A, last word loaded together with start.
    manual = 1'b0;
    for (int i = 0; i < 4; i++) load(6'(i), prog_a[i]);
    run_prog(32'h0000_0FFF, 1'b1, 6'd4, prog_a[4], -1, lat);
    chk1("a_pass", pass, 1'b1);
    chk1("a_fault", fault, 1'b0);
    chk1("a_timeout", timeout, 1'b0);
    chk("a_cycles", cycle_count, 32'd6);
    chk("a_latency", 32'(lat), 32'(6 + RSTC + 1));
    chk1("a_busy_low", busy, 1'b0);
    chk1("a_clk_en_low", cpu_clk_enable, 1'b0);
    tick();
    tick();
    chk1("a_done_held", done, 1'b1);
    chk("a_cycles_held", cycle_count, 32'd6);

    // Program B: or replaced by and.
    load(6'd2, 32'h0061_1024);
    run_prog(32'h0000_0FFF, 1'b0, 6'd0, 32'h0, -1, lat);
    chk1("b_pass", pass, 1'b0);
    chk("b_cycles", cycle_count, 32'd6);

    // Infinite loop hits the timeout.
    load(6'd2, prog_a[2]);
    load(6'd0, 32'h1000_FFFF);
    run_prog(32'h0, 1'b0, 6'd0, 32'h0, -1, lat);
    chk1("to_timeout", timeout, 1'b1);
    chk1("to_pass", pass, 1'b0);
    chk("to_cycles", cycle_count, 32'd50);
    chk("to_latency", 32'(lat), 32'(50 + RSTC + 1));
    load(6'd0, prog_a[0]);

    // Fetch outside the store, then misaligned, during RUN.
    manual = 1'b1;
    for (int f = 0; f < 2; f++) begin
      instr_address = RV;
      active        = 1'b0;
      register_v0   = 32'h1234;
      expected_v0   = 32'h1234;
      start         = 1'b1;
      tick();
      tick();
      tick();
      chk1("fault_cleared", fault, 1'b0);
      active        = 1'b1;
      instr_address = (f == 0) ? RV + 32'd256 : RV + 32'd2;
      #1;
      chk("fault_rdata", instr_readdata, 32'h0);
      tick();
      chk1("fault_set", fault, 1'b1);
      instr_address = RV;
      active        = 1'b0;
      tick();
      tick();
      chk1("fault_done", done, 1'b1);
      chk1("fault_pass", pass, 1'b0);
      chk1("fault_sticky", fault, 1'b1);
      chk("fault_cycles", cycle_count, 32'd2);
    end

    // Asynchronous reset three cycles into RUN.
    manual      = 1'b0;
    expected_v0 = 32'h0000_0FFF;
    start       = 1'b1;
    tick();
    repeat (RSTC + 3) tick();
    chk("mid_cycles", cycle_count, 32'd3);
    #2 reset = 1'b1;
    #1;
    chk1("mid_cpu_reset", cpu_reset, 1'b1);
    chk1("mid_busy", busy, 1'b0);
    chk1("mid_clk_en", cpu_clk_enable, 1'b0);
    chk("mid_cycles_clr", cycle_count, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    run_prog(32'h0000_0FFF, 1'b0, 6'd0, 32'h0, -1, lat);
    chk1("rerun_pass", pass, 1'b1);
    chk("rerun_cycles", cycle_count, 32'd6);

    // start and load_en during RUN are ignored.
    run_prog(32'h0000_0FFF, 1'b0, 6'd0, 32'h0, 4, lat);
    chk1("dist_pass", pass, 1'b1);
    chk("dist_cycles", cycle_count, 32'd6);
    chk("dist_latency", 32'(lat), 32'(6 + RSTC + 1));
    manual        = 1'b1;
    instr_address = RV;
    #1;
    chk("dist_word0", instr_readdata, model_mem[0]);
    manual = 1'b0;

    // Random straight-line programs graded against a register model.
    for (int r = 0; r < 8; r++) begin
      logic [31:0] m [8];
      logic [31:0] w, ev;
      logic [15:0] imm;
      logic [2:0]  d, s1, s2;
      int          n, k;
      bit          good;
      m = '{default: 32'h0};
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        d   = 3'($urandom_range(1, 7));
        s1  = 3'($urandom);
        s2  = 3'($urandom);
        imm = 16'($urandom);
        k   = $urandom_range(0, 3);
        case (k)
          0: begin
            w    = {6'h09, 2'b0, s1, 2'b0, d, imm};
            m[d] = m[s1] + {{16{imm[15]}}, imm};
          end
          1: begin
            w    = {6'h00, 2'b0, s1, 2'b0, s2, 2'b0, d, 5'h0, 6'h21};
            m[d] = m[s1] + m[s2];
          end
          2: begin
            w    = {6'h00, 2'b0, s1, 2'b0, s2, 2'b0, d, 5'h0, 6'h25};
            m[d] = m[s1] | m[s2];
          end
          default: begin
            w    = {6'h00, 2'b0, s1, 2'b0, s2, 2'b0, d, 5'h0, 6'h24};
            m[d] = m[s1] & m[s2];
          end
        endcase
        load(6'(i), w);
      end
      s1   = 3'($urandom);
      s2   = 3'($urandom);
      m[2] = m[s1] + m[s2];
      load(6'(n), {6'h00, 2'b0, s1, 2'b0, s2, 5'd2, 5'h0, 6'h21});
      load(6'(n + 1), 32'h0000_0008);
      good = 1'($urandom_range(0, 1));
      ev   = good ? m[2] : m[2] ^ (32'h1 << $urandom_range(0, 31));
      run_prog(ev, 1'b0, 6'd0, 32'h0, -1, lat);
      chk1("rnd_pass", pass, good);
      chk("rnd_cycles", cycle_count, 32'(n + 3));
      chk("rnd_latency", 32'(lat), 32'(n + 3 + RSTC + 1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_prog_checker.md
# mips_prog_checker

Self-checking program harness for the `mips_cpu_harvard` core, replacing hand-sequenced per-instruction stimulus with a loadable, parametrised program store and a run/check state machine. It serves instructions combinationally to the CPU, drives CPU reset and clock enable, and waits for the CPU to halt or time out. It then compares `register_v0` against an expected value and reports pass/fail with a cycle count. It sits beside the CPU in every instruction-level bench and in FPGA bring-up.

## Interface
- `PROG_DEPTH`, 64: program store depth in 32-bit words (power of two, 4..1024).
- `RESET_VECTOR`, 32'hBFC00000: byte address of program word 0.
- `TIMEOUT_CYCLES`, 10000: maximum RUN cycles before fail.
- `RST_CYCLES`, 2: cycles `cpu_reset` is held high.
- `clk` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; forces IDLE and clears all outputs.
- `start` in 1: one-cycle pulse; begins a run when in IDLE.
- `expected_v0` in 32: golden `register_v0`, latched on accepted `start`.
- `load_en` in 1: write one program word (accepted in IDLE or DONE only).
- `load_addr` in log2(PROG_DEPTH): word index for load.
- `load_data` in 32: instruction word for load.
- `cpu_reset` out 1: reset to CPU.
- `cpu_clk_enable` out 1: clock enable to CPU.
- `active` in 1: CPU active flag.
- `register_v0` in 32: CPU v0 value.
- `instr_address` in 32: CPU fetch address.
- `instr_readdata` out 32: combinational instruction word.
- `busy` out 1: high in RST, RUN, CHECK.
- `done` out 1: sticky, high in DONE.
- `pass` out 1: valid while `done`; v0 matched and no fault/timeout.
- `fault` out 1: sticky in run; fetch outside store or misaligned.
- `timeout` out 1: sticky in run; TIMEOUT_CYCLES reached.
- `cycle_count` out 32: RUN cycles elapsed, frozen at DONE.

## Operation
- States: IDLE, RST, RUN, CHECK, DONE.
- IDLE/DONE + `start` -> RST: latch `expected_v0`, clear `cycle_count`, `fault`, `timeout`, `pass`, `done`.
- RST: `cpu_reset`=1, `cpu_clk_enable`=1 for RST_CYCLES cycles, then RUN.
- RUN: `cpu_reset`=0, `cpu_clk_enable`=1, `cycle_count` +1 per cycle.
- Exit RUN -> CHECK when `active`=0 is sampled after `active`=1 was seen in this run, or when `cycle_count` reaches TIMEOUT_CYCLES-1 (set `timeout`).
- CHECK (1 cycle): `cpu_clk_enable`=0; `pass` = (`register_v0`==latched expected) & !`fault` & !`timeout`; -> DONE.
- DONE: `done`=1, outputs held until next `start` or `reset`.
- Fetch: index = (`instr_address` - RESET_VECTOR) >> 2. When in range and bits[1:0]==0, return the stored word; otherwise return 32'h0 (NOP) and set `fault` (RUN only).
- Store is not cleared by `reset`; unwritten words read 0.
- `start` while busy: ignored. `load_en` while busy: ignored.
- Simultaneous `load_en` and `start` in IDLE: both taken; the loaded word is visible before the first RUN fetch.
- `reset` mid-run: immediate IDLE. `cpu_reset` goes 1 asynchronously; all other outputs go 0.

## Timing
- Reset values: `cpu_reset`=1, `cpu_clk_enable`=0, and `busy`, `done`, `pass`, `fault`, `timeout`, `cycle_count` all 0. `instr_readdata` is combinational from the store.
- `start` accepted at edge N: `busy`=1 and `cpu_reset`=1 from N+1; RUN from N+1+RST_CYCLES.
- Load written at edge; readable via `instr_readdata` the following cycle.
- End detect to `done`: 2 cycles (CHECK, then DONE).

## Structure
- Package `mips_tb_pkg`: state enum `chk_state_t`, `NOP_WORD`=32'h0, default RESET_VECTOR.
- Sub-module `prog_rom`: PROG_DEPTH×32 store, synchronous write, asynchronous read, plus the range/alignment decode and `fault` qualifier.
- Top holds the FSM, counters and comparator.

## Test plan
- Load `addiu $3,$0,0x0f0f`, `addiu $1,$0,0x00ff`, `or $2,$3,$1`, move to v0, halt; expected 32'h0fff -> `done`=1, `pass`=1, `fault`=0.
- Same program with expected 32'h0fff, then corrupt the `or` word to `and` -> `pass`=0 (v0=32'h000f).
- Program of `beq $0,$0,-1` (infinite loop), TIMEOUT_CYCLES=50 -> `timeout`=1, `pass`=0, `cycle_count`=50.
- Jump to RESET_VECTOR+4*PROG_DEPTH -> `instr_readdata`=0, `fault`=1, `pass`=0 after halt.
- Assert `reset` 3 cycles into RUN -> `cpu_reset`=1 and `busy`=0 within the cycle; the next `start` reruns with `cycle_count` reset.
- `start` and `load_en` pulsed during RUN -> no restart; the store word is unchanged when read back in DONE.
